// File: rtl/dram_rw_scheduler.sv
// Arbitrates AXI-Lite-style reads and buffered writes onto one DRAM request port.
// Reads have priority. A burst limit stops reads from starving writes, and a watermark decides when the write queue is drained.
module dram_rw_scheduler #(
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 512,
  parameter int WrDepth      = 8,
  parameter int HiWm         = 6,
  parameter int LoWm         = 2,
  parameter int MaxReadBurst = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rd_valid_i,
  output logic                           rd_ready_o,
  input  logic [AddrWidth-1:0]           rd_addr_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [AddrWidth-1:0]           wr_addr_i,
  input  logic [DataWidth-1:0]           wr_data_i,
  input  logic [DataWidth/8-1:0]         wr_strb_i,
  output logic                           req_valid_o,
  input  logic                           req_ready_i,
  output logic                           req_we_o,
  output logic [AddrWidth-1:0]           req_addr_o,
  output logic [DataWidth-1:0]           req_wdata_o,
  output logic [DataWidth/8-1:0]         req_wstrb_o,
  output logic [$clog2(WrDepth+1)-1:0]   wq_count_o,
  output logic                           drain_o
);

  localparam int StrbWidth  = DataWidth / 8;
  localparam int PtrWidth   = $clog2(WrDepth);
  localparam int CntWidth   = $clog2(WrDepth + 1);
  localparam int BurstWidth = $clog2(MaxReadBurst + 1);

  localparam logic [CntWidth-1:0]   DepthC    = CntWidth'(WrDepth);
  localparam logic [CntWidth-1:0]   HiWmC     = CntWidth'(HiWm);
  localparam logic [CntWidth-1:0]   LoWmC     = CntWidth'(LoWm);
  localparam logic [BurstWidth-1:0] MaxBurstC = BurstWidth'(MaxReadBurst);

  typedef enum logic {
    READ_PRIO = 1'b0,
    DRAIN     = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q [WrDepth];
  logic [DataWidth-1:0] data_q [WrDepth];
  logic [StrbWidth-1:0] strb_q [WrDepth];
  logic [WrDepth-1:0]   vld_q, vld_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [BurstWidth-1:0] burst_q, burst_d;
  logic                 lock_q, lock_d, lock_we_q, lock_we_d;
  logic [AddrWidth-1:0] lock_addr_q, lock_addr_d;

  logic hit, hazard, full, empty;
  logic sel_rd, sel_wr, enq, deq, rd_acc;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  // A read must not overtake any queued write to the same line.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WrDepth; i++) begin
      if (vld_q[i] && (addr_q[i] == rd_addr_i)) hit = 1'b1;
    end
  end
  assign hazard = rd_valid_i && hit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= READ_PRIO;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READ_PRIO: if ((count_q >= HiWmC) || hazard) state_d = DRAIN;
      DRAIN:     if ((count_q <= LoWmC) && !hazard) state_d = READ_PRIO;
      default:   state_d = READ_PRIO;
    endcase
  end

  // A grant left unaccepted stays locked, whatever the state does meanwhile.
  always_comb begin
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    if (lock_q) begin
      sel_rd = !lock_we_q;
      sel_wr = lock_we_q;
    end else if (state_q == DRAIN) begin
      sel_wr = !empty;
    end else if (rd_valid_i && !hazard && ((burst_q < MaxBurstC) || empty)) begin
      sel_rd = 1'b1;
    end else begin
      sel_wr = !empty;
    end

    req_valid_o = rst_ni && (sel_rd || sel_wr);
    req_we_o    = rst_ni && sel_wr;
    req_addr_o  = '0;
    req_wdata_o = '0;
    req_wstrb_o = '0;
    if (rst_ni && sel_wr) begin
      req_addr_o  = addr_q[rd_ptr_q];
      req_wdata_o = data_q[rd_ptr_q];
      req_wstrb_o = strb_q[rd_ptr_q];
    end else if (rst_ni && sel_rd) begin
      req_addr_o = lock_q ? lock_addr_q : rd_addr_i;
    end
    rd_ready_o = rst_ni && sel_rd && req_ready_i;
    wr_ready_o = rst_ni && !full;
  end

  assign enq    = wr_valid_i && wr_ready_o;
  assign deq    = req_valid_o && req_ready_i && sel_wr;
  assign rd_acc = req_valid_o && req_ready_i && sel_rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrWidth'(enq);
    rd_ptr_d = rd_ptr_q + PtrWidth'(deq);
    vld_d    = vld_q;
    if (enq) vld_d[wr_ptr_q] = 1'b1;
    if (deq) vld_d[rd_ptr_q] = 1'b0;

    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase

    burst_d = burst_q;
    if (empty || deq)                          burst_d = '0;
    else if (rd_acc && (burst_q != MaxBurstC)) burst_d = burst_q + BurstWidth'(1);

    lock_d      = req_valid_o && !req_ready_i;
    lock_we_d   = sel_wr;
    lock_addr_d = req_addr_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      burst_q     <= '0;
      lock_q      <= 1'b0;
      lock_we_q   <= 1'b0;
      lock_addr_q <= '0;
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      burst_q     <= burst_d;
      lock_q      <= lock_d;
      lock_we_q   <= lock_we_d;
      lock_addr_q <= lock_addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= wr_addr_i;
      data_q[wr_ptr_q] <= wr_data_i;
      strb_q[wr_ptr_q] <= wr_strb_i;
    end
  end

  assign wq_count_o = count_q;
  assign drain_o    = (state_q == DRAIN);

endmodule
